// File: rtl/core_ctrl_pkg.sv
// Shared control-path types for the core's hazard/stall sequencing.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the same
// cycle load the value one.
module sat_counter #(
  parameter int          W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base != MAX)) cnt_d = base + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 6-stage core: load-use, mul/div occupancy,
// memory wait states and mispredict squash, plus a stall-cycle counter.
module pipeline_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             UseRs1D,
  input  logic             UseRs2D,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             MemReadE,
  input  logic             MemReadM,
  input  logic             MemReqM,
  input  logic             DmemReady,
  input  logic             ImemReady,
  input  logic             MdStartE,
  input  logic             MdDone,
  input  logic             BranchMispredE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MdTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [1:0]       CtrlState
);

  localparam int              MD_W   = $clog2(MD_TIMEOUT + 1);
  localparam logic [MD_W-1:0] MD_MAX = MD_W'(MD_TIMEOUT);

  ctrl_state_e     state_q, state_d;
  logic            pend_q, pend_d, to_q, to_d;
  logic            mem_hold, md_hold, md_clr, release_c, redirect, md_reach;
  logic            rs1_hit, rs2_hit, lu_hit;
  logic [MD_W-1:0] md_cnt;

  assign rs1_hit = UseRs1D && (Rs1D != REG_X0) &&
                   ((MemReadE && RegWriteE && (Rs1D == RdE)) ||
                    (MemReadM && RegWriteM && (Rs1D == RdM)));
  assign rs2_hit = UseRs2D && (Rs2D != REG_X0) &&
                   ((MemReadE && RegWriteE && (Rs2D == RdE)) ||
                    (MemReadM && RegWriteM && (Rs2D == RdM)));
  assign lu_hit  = rs1_hit || rs2_hit;

  always_comb begin
    state_d   = state_q;
    mem_hold  = 1'b0;
    md_hold   = 1'b0;
    md_clr    = 1'b0;
    release_c = 1'b0;
    case (state_q)
      MEM_WAIT: begin
        if (DmemReady) begin
          state_d   = RUN;
          release_c = 1'b1;
        end else begin
          mem_hold = 1'b1;
        end
      end
      MD_BUSY: begin
        if (MdDone) begin
          state_d   = RUN;
          release_c = 1'b1;
        end else begin
          md_hold = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        if (MemReqM && !DmemReady) begin
          state_d  = MEM_WAIT;
          mem_hold = 1'b1;
        end else if (MdStartE && !MdDone) begin
          state_d = MD_BUSY;
          md_hold = 1'b1;
          md_clr  = 1'b1;
        end
      end
    endcase
  end

  // A held mispredict is replayed on the first cycle E is free again; the same
  // redirect squashes the instruction that would otherwise cause a load-use stall.
  assign redirect = BranchMispredE || pend_q;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else if (mem_hold) begin
      {StallF, StallD, StallE, StallM, FlushW} = '1;
    end else if (md_hold) begin
      {StallF, StallD, StallE, FlushM} = '1;
    end else if (redirect) begin
      {FlushD, FlushE} = '1;
    end else if (!release_c) begin
      if (lu_hit) begin
        {StallF, StallD, FlushE} = '1;
      end else if (!ImemReady) begin
        {StallF, FlushD} = '1;
      end
    end
  end

  // Busy cycle that brings the counter to the limit, entry cycle included.
  assign md_reach = md_hold && (md_clr ? (MD_MAX == MD_W'(1)) : (md_cnt == MD_MAX - 1'b1));
  assign pend_d   = StallE ? (pend_q || BranchMispredE) : 1'b0;
  assign to_d     = to_q || md_reach;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
    end
  end

  sat_counter #(.W(MD_W), .MAX(MD_MAX)) u_md_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (md_hold),
    .clr_i (md_clr),
    .cnt_o (md_cnt)
  );

  sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_stall_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (StallF),
    .clr_i (1'b0),
    .cnt_o (StallCycles)
  );

  assign MdTimeout = to_q;
  assign CtrlState = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MD_TO = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, RdE, RdM;
  logic UseRs1D, UseRs2D, RegWriteE, RegWriteM, MemReadE, MemReadM;
  logic MemReqM, DmemReady, ImemReady, MdStartE, MdDone, BranchMispredE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdTimeout;
  logic [CW-1:0] StallCycles;
  logic [1:0] CtrlState;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .RdE(RdE), .RdM(RdM), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .MemReadE(MemReadE), .MemReadM(MemReadM), .MemReqM(MemReqM), .DmemReady(DmemReady),
    .ImemReady(ImemReady), .MdStartE(MdStartE), .MdDone(MdDone),
    .BranchMispredE(BranchMispredE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MdTimeout(MdTimeout), .StallCycles(StallCycles), .CtrlState(CtrlState)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the controller is waiting for, how long, and pending squash.
  bit m_mem, m_md, m_pend, m_to;
  int m_mdcnt, m_cnt;
  bit e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW;
  bit g_wait_mem, g_wait_md, g_bm, g_rst;

  function automatic bit dep(input logic [4:0] rs, input logic use_rs);
    return use_rs && (rs != 5'd0) &&
           ((MemReadE && RegWriteE && rs == RdE) || (MemReadM && RegWriteM && rs == RdM));
  endfunction

  task automatic model_eval();
    bit fin;
    fin = 0;
    {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW} = '0;
    g_wait_mem = 0;
    g_wait_md  = 0;
    g_bm  = BranchMispredE;
    g_rst = rst;
    if (!rst) begin
      if (m_mem) begin
        if (DmemReady) fin = 1; else g_wait_mem = 1;
      end else if (m_md) begin
        if (MdDone) fin = 1; else g_wait_md = 1;
      end else if (MemReqM && !DmemReady) g_wait_mem = 1;
      else if (MdStartE && !MdDone) g_wait_md = 1;

      if (g_wait_mem) {e_sF, e_sD, e_sE, e_sM, e_fW} = '1;
      else if (g_wait_md) {e_sF, e_sD, e_sE, e_fM} = '1;
      else if (BranchMispredE || m_pend) {e_fD, e_fE} = '1;
      else if (!fin) begin
        if (dep(Rs1D, UseRs1D) || dep(Rs2D, UseRs2D)) {e_sF, e_sD, e_fE} = '1;
        else if (!ImemReady) {e_sF, e_fD} = '1;
      end
    end
  endtask

  task automatic model_commit();
    if (g_rst) begin
      m_mem = 0; m_md = 0; m_pend = 0; m_to = 0; m_mdcnt = 0; m_cnt = 0;
    end else begin
      m_pend = e_sE ? (m_pend | g_bm) : 1'b0;
      if (g_wait_md) begin
        m_mdcnt = m_md ? ((m_mdcnt < MD_TO) ? m_mdcnt + 1 : MD_TO) : 1;
        if (m_mdcnt == MD_TO) m_to = 1;
      end
      m_mem = g_wait_mem;
      m_md  = g_wait_md;
      if (e_sF && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic tick(input string tag);
    int exp_state;
    @(negedge clk);
    model_eval();
    exp_state = m_mem ? 2 : (m_md ? 1 : 0);
    chk({tag, "/ctl"}, {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW},
        {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_fW});
    chk({tag, "/state"}, CtrlState, exp_state);
    chk({tag, "/tmo"}, MdTimeout, m_to);
    chk({tag, "/cyc"}, StallCycles, m_cnt);
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic idle();
    rst = 0; Rs1D = 0; Rs2D = 0; UseRs1D = 0; UseRs2D = 0; RdE = 0; RdM = 0;
    RegWriteE = 0; RegWriteM = 0; MemReadE = 0; MemReadM = 0; MemReqM = 0;
    DmemReady = 1; ImemReady = 1; MdStartE = 0; MdDone = 0; BranchMispredE = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick("rst");
    rst = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    do_reset();
    #1;
    chk("rst_state", CtrlState, 0);
    chk("rst_cyc", StallCycles, 0);
    chk("rst_tmo", MdTimeout, 0);

    // load in E, consumer in D: two stall cycles
    MemReadE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5; UseRs1D = 1;
    #1;
    chk("lu1_stallD", StallD, 1);
    chk("lu1_flushE", FlushE, 1);
    tick("lu1");
    MemReadE = 0; RegWriteE = 0; MemReadM = 1; RegWriteM = 1; RdM = 5;
    #1;
    chk("lu2_stallF", StallF, 1);
    chk("lu2_flushE", FlushE, 1);
    tick("lu2");
    MemReadM = 0; RegWriteM = 0;
    #1;
    chk("lu3_stallD", StallD, 0);
    chk("lu_cyc", StallCycles, 2);
    tick("lu3");

    idle();
    MemReadE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0; UseRs1D = 1;
    #1;
    chk("x0_stallF", StallF, 0);
    tick("x0");

    // mul/div: entry + 4 busy cycles, released by MdDone
    do_reset();
    MdStartE = 1;
    #1;
    chk("md_enter_stallE", StallE, 1);
    tick("md0");
    MdStartE = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("md_busy_state", CtrlState, 1);
      chk("md_busy_flushM", FlushM, 1);
      tick("md");
    end
    MdDone = 1;
    #1;
    chk("md_done_stallF", StallF, 0);
    tick("mddone");
    MdDone = 0;
    #1;
    chk("md_after_state", CtrlState, 0);
    chk("md_cyc", StallCycles, 5);
    chk("md_tmo", MdTimeout, 0);
    tick("md_after");

    // timeout with no MdDone, then reset mid-busy
    do_reset();
    MdStartE = 1;
    tick("to0");
    MdStartE = 0;
    for (int i = 0; i < 6; i++) tick("to");
    #1;
    chk("to_early", MdTimeout, 0);
    tick("to7");
    #1;
    chk("to_set", MdTimeout, 1);
    tick("to8");
    rst = 1;
    #1;
    chk("to_rst_stallF", StallF, 0);
    chk("to_rst_flushM", FlushM, 0);
    tick("to_rst");
    rst = 0;
    #1;
    chk("to_clr", MdTimeout, 0);
    chk("to_clr_state", CtrlState, 0);

    // data memory wait with a load-use hit hidden behind it
    idle();
    MemReqM = 1; DmemReady = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin MemReadE = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; UseRs2D = 1; end
      #1;
      chk("mw_stallM", StallM, 1);
      chk("mw_flushW", FlushW, 1);
      chk("mw_flushE", FlushE, 0);
      tick("mw");
    end
    idle();
    MemReqM = 1;
    #1;
    chk("mw_rel_stallF", StallF, 0);
    chk("mw_rel_stallM", StallM, 0);
    tick("mw_rel");

    // mispredict held across mul/div busy
    idle();
    MdStartE = 1;
    tick("bp0");
    MdStartE = 0; BranchMispredE = 1;
    #1;
    chk("bp_busy_flushD", FlushD, 0);
    tick("bp1");
    BranchMispredE = 0;
    tick("bp2");
    MdDone = 1;
    #1;
    chk("bp_done_flushD", FlushD, 1);
    chk("bp_done_flushE", FlushE, 1);
    tick("bp3");
    MdDone = 0;
    #1;
    chk("bp_after_flushD", FlushD, 0);
    tick("bp4");

    // mispredict beats load-use
    idle();
    MemReadE = 1; RegWriteE = 1; RdE = 9; Rs1D = 9; UseRs1D = 1; BranchMispredE = 1;
    #1;
    chk("bplu_stallD", StallD, 0);
    chk("bplu_flushD", FlushD, 1);
    chk("bplu_flushE", FlushE, 1);
    tick("bplu");

    // randomized traffic, long enough to saturate the stall counter
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      Rs1D = 5'($urandom_range(3)); Rs2D = 5'($urandom_range(3));
      RdE = 5'($urandom_range(3)); RdM = 5'($urandom_range(3));
      UseRs1D = 1'($urandom_range(1)); UseRs2D = 1'($urandom_range(1));
      RegWriteE = 1'($urandom_range(1)); RegWriteM = 1'($urandom_range(1));
      MemReadE = ($urandom_range(3) == 0); MemReadM = ($urandom_range(3) == 0);
      MemReqM = ($urandom_range(3) == 0); DmemReady = ($urandom_range(4) > 1);
      ImemReady = ($urandom_range(4) > 0); MdStartE = ($urandom_range(7) == 0);
      MdDone = ($urandom_range(5) == 0); BranchMispredE = ($urandom_range(7) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall/flush sequencer for the 6-stage core.
- Sits beside the data forwarding unit. It covers the hazards forwarding cannot resolve:
  - load-use on data not yet returned
  - multi-cycle mul/div occupancy of E
  - data/instruction memory wait states
  - branch mispredict squash
- Drives per-stage stall (pipeline-register hold) and flush (bubble insert) controls, and keeps a stall-cycle performance counter.

Parameters:
- MD_TIMEOUT, 64: maximum mul/div busy cycles before MdTimeout is flagged.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers in D
- UseRs1D, UseRs2D  in  1  the D instruction actually reads Rs1/Rs2
- RdE, RdM  in  5  destinations in E and M
- RegWriteE, RegWriteM  in  1  register write enables in E and M
- MemReadE, MemReadM  in  1  load in E and M
- MemReqM  in  1  data memory access in M
- DmemReady  in  1  data memory completes this cycle
- ImemReady  in  1  instruction fetch valid this cycle
- MdStartE  in  1  mul/div instruction entered E
- MdDone  in  1  mul/div result valid
- BranchMispredE  in  1  mispredict resolved in E
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  insert a bubble into the corresponding register
- MdTimeout  out  1  sticky error flag
- StallCycles  out  CNT_W  saturating count of cycles with StallF=1
- CtrlState  out  2  debug copy of the FSM state

Behaviour:
- Reset (rst=1 at a clk edge): state=RUN, MdTimeout=0, StallCycles=0, MD counter=0, PendFlush=0. While rst=1, all Stall*/Flush* = 0. Reset mid-MD_BUSY or mid-MEM_WAIT aborts immediately.
- FSM states (CtrlState encoding):
  - RUN=0
  - MD_BUSY=1
  - MEM_WAIT=2
  - (3 unused, decodes as RUN)
- RUN:
  - MemReqM & !DmemReady → outputs this cycle as MEM_WAIT; next state MEM_WAIT.
  - else MdStartE & !MdDone → outputs as MD_BUSY; next state MD_BUSY; MD counter=1.
  - else combinational hazards only (below).
- MEM_WAIT:
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - On DmemReady: stalls drop in that same cycle; next state RUN.
  - Highest priority: also masks MD_BUSY entry and load-use.
- MD_BUSY:
  - StallF=StallD=StallE=1, FlushM=1.
  - MD counter increments per cycle, saturating at MD_TIMEOUT.
  - On MdDone: stalls drop in that same cycle; next state RUN.
  - Counter reaching MD_TIMEOUT without MdDone sets MdTimeout (sticky until rst); the FSM keeps waiting.
  - Entering MEM_WAIT from MD_BUSY is impossible, because M already holds a bubble.
- Load-use (RUN only), combinational:
  - hit = (UseRs1D & Rs1D!=0 & ((MemReadE & RegWriteE & Rs1D==RdE) | (MemReadM & RegWriteM & Rs1D==RdM))), and likewise for Rs2.
  - hit → StallF=StallD=1, FlushE=1.
  - Latency: a load in E gives a 2-cycle stall; a load in M gives 1 cycle. Load data is forwardable only from W.
- Imem not ready (RUN, no other stall): StallF=1, FlushD=1. D/E/M continue.
- Branch mispredict:
  - If E is not stalled: FlushD=1 and FlushE=1 this cycle. Load-use and imem stalls are suppressed, because the dependent instruction is squashed.
  - If E is stalled (MEM_WAIT/MD_BUSY): set PendFlush. Apply FlushD/FlushE in the first cycle StallE=0, then clear PendFlush.
  - Simultaneous MdStartE & BranchMispredE: the mispredict flush applies to D and E younger slots only; the mul/div in E still proceeds to MD_BUSY.
- Invariant: for any stage, Stall and Flush are never both 1; Stall wins except in the documented pairs.
- StallCycles increments on every cycle with StallF=1 and saturates at all-ones.

Decomposition:
- Shared package core_ctrl_pkg: ctrl_state_e enum (RUN, MD_BUSY, MEM_WAIT) and the REG_X0 constant.
- One sub-module: sat_counter (parameterised width, inc, clr). Used for StallCycles and the MD counter.
- Load-use compare stays inline.

Test Plan:
- lw x5 in E, D reads x5 (UseRs1D=1) → StallF/StallD=1 and FlushE=1 for 2 consecutive cycles, then released; StallCycles=2.
- Rs1D=0 with MemReadE, RdE=0 → no stall.
- MdStartE; MdDone on the 5th cycle → StallF/D/E=1 and FlushM=1 for 5 cycles, CtrlState=1; then RUN; MdTimeout=0.
- With MD_TIMEOUT=8, MdDone never arrives → MdTimeout=1 on the 8th busy cycle; rst then clears everything and outputs drop in the same cycle.
- MemReqM with DmemReady low for 3 cycles → StallF..StallM=1 and FlushW=1 for 3 cycles, released in the DmemReady cycle; a load-use hit during the wait produces no FlushE.
- BranchMispredE during MD_BUSY → no flush while busy; FlushD=FlushE=1 exactly in the MdDone cycle.
- BranchMispredE with a simultaneous load-use hit → flush only, no StallD.
